if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage: PC register and IF/ID pipeline register.
//            Handles load-use stalls, EX redirects and halt requests, and
//            keeps a sticky misaligned-target flag and a saturating bubble
//            counter. All state updates on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        idex_load,
  input  logic [4:0]  idex_rd,
  input  logic        halt_req,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] sum_out,
  output logic        valid_out,
  output logic        bubble_out,
  output logic        misalign_err,
  output logic [15:0] bubble_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] instr_nxt;
  logic [31:0] pc_out_nxt;
  logic [31:0] sum_out_nxt;
  logic        valid_nxt;
  logic        hazard;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;   // wraps naturally modulo 2^32

  // Load-use hazard: the ID/EX load writes a register the IF/ID instruction reads
  assign hazard = idex_load && (idex_rd != 5'd0) && valid_out &&
                  ((idex_rd == instr_out[19:15]) || (idex_rd == instr_out[24:20]));

  // A bubble is only inserted from RUN; the STALL cycle lets the held
  // instruction proceed. Follows hazard even when a redirect wins.
  assign bubble_out = (state == RUN) && hazard;

  // Next-state, next-PC and next IF/ID contents
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr_out;
    pc_out_nxt  = pc_out;
    sum_out_nxt = sum_out;
    valid_nxt   = valid_out;

    if (redirect_valid) begin
      pc_nxt      = {redirect_pc[31:2], 2'b00};
      instr_nxt   = NOP_INSTR;
      pc_out_nxt  = 32'd0;
      sum_out_nxt = 32'd0;
      valid_nxt   = 1'b0;
      state_nxt   = RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            state_nxt = STALL;
          end else if (halt_req) begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            state_nxt = HALT;
          end else begin
            pc_nxt      = pc_plus4;
            instr_nxt   = imem_rdata;
            pc_out_nxt  = pc;
            sum_out_nxt = pc_plus4;
            valid_nxt   = 1'b1;
          end
        end
        STALL: begin
          pc_nxt      = pc_plus4;
          instr_nxt   = imem_rdata;
          pc_out_nxt  = pc;
          sum_out_nxt = pc_plus4;
          valid_nxt   = 1'b1;
          state_nxt   = RUN;
        end
        HALT: begin
          valid_nxt = 1'b0;
          if (!halt_req) begin
            state_nxt = RUN;   // release edge performs no fetch
          end
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State, PC and IF/ID register update on the falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      instr_out <= NOP_INSTR;
      pc_out    <= 32'd0;
      sum_out   <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_out <= instr_nxt;
      pc_out    <= pc_out_nxt;
      sum_out   <= sum_out_nxt;
      valid_out <= valid_nxt;
    end
  end

  // Sticky misalign flag and saturating bubble/flush counter
  always_ff @(negedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
      bubble_cnt   <= 16'd0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      if ((bubble_out || redirect_valid) && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage using a reference model and a
//            scoreboard queue of expected IF/ID contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] HAZ_ADDR  = 32'h0000_0020;
  localparam logic [31:0] HAZ_INSTR = 32'h0020_8033;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        idex_load;
  logic [4:0]  idex_rd;
  logic        halt_req;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] sum_out;
  logic        valid_out;
  logic        bubble_out;
  logic        misalign_err;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .idex_load(idex_load), .idex_rd(idex_rd), .halt_req(halt_req),
    .instr_out(instr_out), .pc_out(pc_out), .sum_out(sum_out),
    .valid_out(valid_out), .bubble_out(bubble_out),
    .misalign_err(misalign_err), .bubble_cnt(bubble_cnt)
  );

  // Instruction memory: one load-use victim at HAZ_ADDR, address-derived elsewhere
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == HAZ_ADDR) ? HAZ_INSTR : (a ^ 32'hC0DE_0003);
  endfunction
  assign imem_rdata = mem(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model
  typedef struct {
    logic [31:0] pc, instr, pco, sum;
    logic        valid, mis;
    logic [15:0] cnt;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] m_pc, m_instr, m_pco, m_sum;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;
  int          m_st;   // 0 run, 1 stall, 2 halt

  task automatic m_fetch();
    m_instr = mem(m_pc);
    m_pco   = m_pc;
    m_sum   = m_pc + 32'd4;
    m_pc    = m_pc + 32'd4;
    m_valid = 1'b1;
  endtask

  // One falling edge: check combinational outputs, predict, then compare
  task automatic cycle();
    exp_t e;
    logic haz, bub;
    #1;
    haz = idex_load && (idex_rd != 5'd0) && m_valid &&
          ((idex_rd == m_instr[19:15]) || (idex_rd == m_instr[24:20]));
    bub = (m_st == 0) && haz;
    if (!rst) begin
      check("bubble_out", {31'd0, bubble_out}, {31'd0, bub});
      check("imem_addr", imem_addr, m_pc);
    end
    if (rst) begin
      m_pc = RESET_PC; m_st = 0; m_instr = NOP_INSTR; m_pco = 0; m_sum = 0;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else begin
      if ((bub || redirect_valid) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_instr = NOP_INSTR; m_valid = 0; m_pco = 0; m_sum = 0; m_st = 0;
      end else if (m_st == 0) begin
        if (haz) m_st = 1;
        else if (halt_req) begin m_instr = NOP_INSTR; m_valid = 0; m_st = 2; end
        else m_fetch();
      end else if (m_st == 1) begin
        m_fetch(); m_st = 0;
      end else begin
        if (!halt_req) m_st = 0;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pco = m_pco; e.sum = m_sum;
    e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    e = sb.pop_front();
    check("pc", imem_addr, e.pc);
    check("instr_out", instr_out, e.instr);
    check("pc_out", pc_out, e.pco);
    check("sum_out", sum_out, e.sum);
    check("valid_out", {31'd0, valid_out}, {31'd0, e.valid});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
    check("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.cnt});
  endtask

  task automatic jump(input logic [31:0] tgt);
    redirect_valid = 1'b1; redirect_pc = tgt;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] cnt_before;
    rst = 1; redirect_valid = 0; redirect_pc = 0; idex_load = 0; idex_rd = 0; halt_req = 0;
    cycle();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_instr", instr_out, NOP_INSTR);
    check("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    rst = 0;

    // free-running fetch from RESET_PC
    cycle(); check("f0_pc_out", pc_out, 32'd0);  check("f0_sum", sum_out, 32'd4);
    cycle(); check("f1_pc_out", pc_out, 32'd4);  check("f1_sum", sum_out, 32'd8);
    cycle(); check("f2_pc_out", pc_out, 32'd8);  check("f2_sum", sum_out, 32'd12);
    check("f2_valid", {31'd0, valid_out}, 32'd1);

    // load-use stall: one bubble, PC held, then fetch resumes
    jump(HAZ_ADDR);
    cycle(); check("haz_instr", instr_out, HAZ_INSTR);
    idex_load = 1; idex_rd = 5'd2;
    cnt_before = bubble_cnt;
    #1 check("haz_bubble", {31'd0, bubble_out}, 32'd1);
    cycle();
    check("haz_pc_held", imem_addr, 32'h24);
    check("haz_cnt", {16'd0, bubble_cnt}, {16'd0, cnt_before} + 32'd1);
    cycle();   // STALL: load still flagged, bubble must drop
    check("stall_resume_pc_out", pc_out, 32'h24);
    idex_load = 0;

    // rd = x0 never stalls
    jump(HAZ_ADDR);
    cycle();
    idex_load = 1; idex_rd = 5'd0;
    #1 check("x0_no_bubble", {31'd0, bubble_out}, 32'd0);
    cycle();
    idex_load = 0;

    // redirect beats hazard; misaligned target
    jump(HAZ_ADDR);
    cycle();
    idex_load = 1; idex_rd = 5'd1; redirect_valid = 1; redirect_pc = 32'h0000_0102;
    cnt_before = bubble_cnt;
    #1 check("redir_haz_bubble", {31'd0, bubble_out}, 32'd1);
    cycle();
    check("redir_pc", imem_addr, 32'h0000_0100);
    check("redir_instr", instr_out, NOP_INSTR);
    check("redir_mis", {31'd0, misalign_err}, 32'd1);
    check("redir_cnt", {16'd0, bubble_cnt}, {16'd0, cnt_before} + 32'd1);
    redirect_valid = 0; idex_load = 0;

    // halt for three cycles at 0x40
    jump(32'h40);
    halt_req = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("halt_valid", {31'd0, valid_out}, 32'd0);
      check("halt_pc", imem_addr, 32'h40);
    end
    halt_req = 0;
    cycle(); check("release_nofetch", {31'd0, valid_out}, 32'd0);
    cycle(); check("release_pc_out", pc_out, 32'h40);

    // PC+4 wrap
    jump(32'hFFFF_FFFC);
    cycle();
    check("wrap_pc", imem_addr, 32'd0);
    check("wrap_sum", sum_out, 32'd0);

    // reset mid-HALT, then first fetch from RESET_PC
    halt_req = 1; cycle();
    rst = 1; cycle();
    rst = 0; halt_req = 0; cycle();
    check("post_halt_rst_pc_out", pc_out, RESET_PC);
    check("post_halt_rst_valid", {31'd0, valid_out}, 32'd1);

    // reset mid-STALL
    jump(HAZ_ADDR); cycle();
    idex_load = 1; idex_rd = 5'd2; cycle();
    rst = 1; cycle();
    rst = 0; idex_load = 0; cycle();
    check("post_stall_rst_pc_out", pc_out, RESET_PC);

    // drive the counter to saturation with back-to-back redirects
    n = 16'hFFFE - int'(m_cnt);
    redirect_valid = 1; redirect_pc = 32'h100;
    repeat (n) @(posedge clk);
    m_cnt = m_cnt + 16'(n);
    m_pc = 32'h100; m_instr = NOP_INSTR; m_valid = 0; m_pco = 0; m_sum = 0; m_st = 0;
    jump(HAZ_ADDR);
    check("sat_reach", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    cycle();
    idex_load = 1; idex_rd = 5'd2;
    cycle();
    check("sat_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    idex_load = 0;
    rst = 1; cycle();
    check("sat_rst_clear", {16'd0, bubble_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
